// File: rtl/filtro_pkg.sv
// filtro_pkg: shared state encoding, default depth and index-width helper for the filter sequencer
package filtro_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_LOAD  = 2'b10
  } state_t;
  localparam int FILTRO_N_TAPS = 4;
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/filtro_control_seq_if.sv
// filtro_control_seq_if: start request and index/decode/status bundle; FILTRO_SEQ_OVERRUN_EN adds overrun/overrun_clr
interface filtro_control_seq_if
  import filtro_pkg::*;
#(
  parameter int N_TAPS = FILTRO_N_TAPS
);
  localparam int CNT_W = clog2w(N_TAPS);
  logic              inicio;
  logic [CNT_W-1:0]  dout;
  logic [N_TAPS-1:0] sel_onehot;
  logic              busy;
  logic              listo;
`ifdef FILTRO_SEQ_OVERRUN_EN
  logic              overrun;
  logic              overrun_clr;
  modport master(output inicio, overrun_clr, input dout, sel_onehot, busy, listo, overrun);
  modport slave(input inicio, overrun_clr, output dout, sel_onehot, busy, listo, overrun);
`else
  modport master(output inicio, input dout, sel_onehot, busy, listo);
  modport slave(input inicio, output dout, sel_onehot, busy, listo);
`endif
endinterface

// File: rtl/filtro_edge_det.sv
// filtro_edge_det: 1-bit history register with rising-edge output
module filtro_edge_det (
  input  logic clock150kHz,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic hist_q;
  always_ff @(posedge clock150kHz or posedge reset)
    if (reset) hist_q <= 1'b0;
    else hist_q <= d_i;
  assign rise_o = d_i & ~hist_q;
endmodule

// File: rtl/filtro_control_seq.sv
// filtro_control_seq: steps a tap index 0..N_TAPS-1 per start, then a LOAD cycle pulsing listo.
// FILTRO_SEQ_OVERRUN_EN adds a sticky overrun flag for starts seen while busy.
module filtro_control_seq
  import filtro_pkg::*;
#(
  parameter int N_TAPS     = FILTRO_N_TAPS,
  parameter bit START_EDGE = 1'b0
) (
  input logic           clock150kHz,
  input logic           reset,
  filtro_control_seq_if.slave bus
);
  localparam int CNT_W = clog2w(N_TAPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_TAPS-1:0] sel_q;
  logic              busy_q;
  logic              listo_q;
  logic              rise;
  logic              start;
  filtro_edge_det u_edge (
    .clock150kHz(clock150kHz),
    .reset      (reset),
    .d_i        (bus.inicio),
    .rise_o     (rise)
  );
  assign start = START_EDGE ? rise : bus.inicio;
  // outputs are registered alongside the state so they track it exactly
  always_ff @(posedge clock150kHz or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      listo_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q <= ST_COUNT;
            sel_q   <= N_TAPS'(1);
            busy_q  <= 1'b1;
          end
        end
        ST_COUNT:
          if (cnt_q == LAST) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            sel_q   <= '0;
            listo_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            sel_q <= sel_q << 1;
          end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          sel_q   <= '0;
          busy_q  <= 1'b0;
          listo_q <= 1'b0;
        end
      endcase
    end
  assign bus.dout       = cnt_q;
  assign bus.sel_onehot = sel_q;
  assign bus.busy       = busy_q;
  assign bus.listo      = listo_q;
`ifdef FILTRO_SEQ_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clock150kHz or posedge reset)
    if (reset) overrun_q <= 1'b0;
    else overrun_q <= (start && busy_q) ? 1'b1 : bus.overrun_clr ? 1'b0 : overrun_q;
  assign bus.overrun = overrun_q;
`endif
endmodule

// File: tb/tb_filtro_control_seq.sv
// tb_filtro_control_seq: directed checks over four sequencer configurations
module tb_filtro_control_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  filtro_control_seq_if #(.N_TAPS(4)) if_a ();
  filtro_control_seq_if #(.N_TAPS(5)) if_b ();
  filtro_control_seq_if #(.N_TAPS(4)) if_c ();
  filtro_control_seq_if #(.N_TAPS(2)) if_d ();
  filtro_control_seq #(.N_TAPS(4), .START_EDGE(1'b0)) dut_a (.clock150kHz(clk), .reset(reset), .bus(if_a));
  filtro_control_seq #(.N_TAPS(5), .START_EDGE(1'b0)) dut_b (.clock150kHz(clk), .reset(reset), .bus(if_b));
  filtro_control_seq #(.N_TAPS(4), .START_EDGE(1'b1)) dut_c (.clock150kHz(clk), .reset(reset), .bus(if_c));
  filtro_control_seq #(.N_TAPS(2), .START_EDGE(1'b0)) dut_d (.clock150kHz(clk), .reset(reset), .bus(if_d));

  typedef struct packed {
    logic       inicio;
    logic [1:0] dout;
    logic [3:0] sel;
    logic       busy;
    logic       listo;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int cyc_pos;
    if_a.inicio = 1'b0;
    if_b.inicio = 1'b0;
    if_c.inicio = 1'b0;
    if_d.inicio = 1'b0;
`ifdef FILTRO_SEQ_OVERRUN_EN
    if_a.overrun_clr = 1'b0;
    if_b.overrun_clr = 1'b0;
    if_c.overrun_clr = 1'b0;
    if_d.overrun_clr = 1'b0;
`endif
    // single start, then a start request while dout=2
    tbl[0]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};

    step();
    step();
    chk("rst_dout", int'(if_a.dout), 0);
    chk("rst_sel", int'(if_a.sel_onehot), 0);
    chk("rst_busy", int'(if_a.busy), 0);
    chk("rst_listo", int'(if_a.listo), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      if_a.inicio = tbl[i].inicio;
      step();
      chk($sformatf("a%0d_dout", i), int'(if_a.dout), int'(tbl[i].dout));
      chk($sformatf("a%0d_sel", i), int'(if_a.sel_onehot), int'(tbl[i].sel));
      chk($sformatf("a%0d_busy", i), int'(if_a.busy), int'(tbl[i].busy));
      chk($sformatf("a%0d_listo", i), int'(if_a.listo), int'(tbl[i].listo));
    end
`ifdef FILTRO_SEQ_OVERRUN_EN
    chk("ovr_sticky", int'(if_a.overrun), 1);
    if_a.overrun_clr = 1'b1;
    step();
    if_a.overrun_clr = 1'b0;
    chk("ovr_clr", int'(if_a.overrun), 0);
    chk("ovr_b_clean", int'(if_b.overrun), 0);
`endif

    // asynchronous reset mid-sequence
    if_a.inicio = 1'b1;
    step();
    if_a.inicio = 1'b0;
    step();
    chk("ar_pre_dout", int'(if_a.dout), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_dout", int'(if_a.dout), 0);
    chk("ar_sel", int'(if_a.sel_onehot), 0);
    chk("ar_busy", int'(if_a.busy), 0);
    chk("ar_listo", int'(if_a.listo), 0);
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses += int'(if_a.listo) + int'(if_a.busy);
    end
    chk("ar_no_listo", pulses, 0);

    // N_TAPS=5 level mode, inicio held: period 7, LOAD at cycles 6,13,20
    if_b.inicio = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      chk($sformatf("b%0d_listo", c), int'(if_b.listo), int'(c % 7 == 6));
      chk($sformatf("b%0d_dmax", c), int'(if_b.dout <= 3'd4), 1);
      if (!if_b.busy || if_b.listo) chk($sformatf("b%0d_sel0", c), int'(if_b.sel_onehot), 0);
      else chk($sformatf("b%0d_sel", c), int'(if_b.sel_onehot), 1 << (c % 7 - 1));
    end
    if_b.inicio = 1'b0;
    step();
    step();

    // edge mode: held high gives one sequence, a new rise gives another
    if_c.inicio = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      pulses += int'(if_c.listo);
    end
    chk("c_held_one", pulses, 1);
    chk("c_held_idle", int'(if_c.busy), 0);
    if_c.inicio = 1'b0;
    step();
    step();
    if_c.inicio = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      pulses += int'(if_c.listo);
    end
    chk("c_second", pulses, 1);
    if_c.inicio = 1'b0;

    // N_TAPS=2 back-to-back: COUNT0, COUNT1, LOAD, IDLE repeating
    if_d.inicio = 1'b1;
    chk("d_cnt_w", $bits(if_d.dout), 1);
    for (int c = 1; c <= 12; c++) begin
      step();
      cyc_pos = (c - 1) % 4;
      chk($sformatf("d%0d_dout", c), int'(if_d.dout), int'(cyc_pos == 1));
      chk($sformatf("d%0d_busy", c), int'(if_d.busy), int'(cyc_pos != 3));
      chk($sformatf("d%0d_listo", c), int'(if_d.listo), int'(cyc_pos == 2));
    end
    if_d.inicio = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/filtro_control_seq.md
Name: filtro_control_seq

Overview:
- Parametrised sequencer for the recursive-filter datapath.
- On an ADC start indication it steps a tap/term index through 0..N_TAPS-1. The index drives the datapath muxes, and a one-hot load decode drives the register enables.
- It then spends one extra LOAD cycle so the last shift completes, and pulses listo.
- Successor to the fixed 4-step controller. It adds configurable depth, a selectable start mode (level or rising edge), a busy indication and a one-hot decode output.

Parameters:
- N_TAPS, 4, number of index steps per conversion; legal range 2..256.
- START_EDGE, 0, start mode: 0 = inicio is level-sensitive; 1 = only a rising edge of inicio starts a sequence.
- CNT_W, derived localparam = max(1, clog2(N_TAPS)), width of the index. It is not overridable.

Ports:
- clock150kHz  input  1  system clock, 150 kHz.
- reset  input  1  asynchronous, active-high.
- inicio  input  1  ADC sample-ready / start request.
- dout  output  CNT_W  current tap index for the muxes/decoder.
- sel_onehot  output  N_TAPS  one-hot of dout; valid in COUNT state only, otherwise all zeros.
- busy  output  1  high whenever the state is not IDLE.
- listo  output  1  one-cycle pulse in the LOAD state.

Behaviour:
- Interface: reset is asynchronous, active-high; the clock is clock150kHz.
- All registers update on the posedge of clock150kHz.
- Reset values: state=IDLE, cnt=0, edge-detect history=0. Outputs under reset: dout=0, sel_onehot=0, busy=0, listo=0.
- States are IDLE, COUNT and LOAD. Outputs are Moore-decoded from state and cnt; no output is taken from inputs combinationally.
- IDLE:
  - cnt is held at 0.
  - The start condition is inicio==1 when START_EDGE=0, or inicio==1 with the previous sampled inicio==0 when START_EDGE=1.
  - When the start condition is true, the next state is COUNT and cnt=0.
- COUNT:
  - dout=cnt and sel_onehot[cnt]=1.
  - If cnt==N_TAPS-1: next state is LOAD and cnt is set to 0. Otherwise cnt increments by 1.
  - cnt never exceeds N_TAPS-1, including for non-power-of-2 N_TAPS; there is no natural wrap.
- LOAD:
  - listo=1 for exactly one cycle and dout=0; next state is IDLE.
- Latency: start accepted at edge k. COUNT occupies cycles k+1..k+N_TAPS, LOAD occupies cycle k+N_TAPS+1, and IDLE is reached at k+N_TAPS+2.
- Restart:
  - With level start and inicio held high, a new sequence starts from IDLE every N_TAPS+2 cycles.
  - With edge start, a held-high inicio yields exactly one sequence.
- inicio while busy is ignored; it is neither queued nor able to restart the sequence.
- The edge-detect history register samples inicio every cycle in every state. As a result, a rise that occurred while busy does not trigger a start on return to IDLE.
- Reset mid-sequence: an immediate return to IDLE with cnt=0, and no listo pulse.

Optional Feature:
- Macro: FILTRO_SEQ_OVERRUN_EN.
- When defined:
  - Adds the output port overrun (1 bit) and the input port overrun_clr (1 bit).
  - overrun is a sticky flag, set in the cycle after a start condition is seen while busy=1.
  - The flag is cleared by overrun_clr (synchronous) or by reset. If set and clear occur in the same cycle, set wins.
- When not defined: neither port exists, and starts during busy are silently dropped.

Decomposition:
- Shared package filtro_pkg:
  - State encoding constants: ST_IDLE=2'b00, ST_COUNT=2'b01, ST_LOAD=2'b10.
  - Default FILTRO_N_TAPS=4.
  - The clog2 width helper function.
- One natural sub-module: filtro_edge_det. It is a 1-bit history register plus a rise output, reused by the ADC interface.
- The one-hot decode stays inline.

Test Plan:
- Reset then a 1-cycle inicio pulse (N_TAPS=4, START_EDGE=0) -> dout reads 0,1,2,3 on the next 4 cycles with sel_onehot 0001,0010,0100,1000. Then listo=1 for exactly 1 cycle, and busy is high for 5 cycles.
- N_TAPS=5, inicio held high, level mode -> listo pulses every 7 cycles, dout never exceeds 4, and sel_onehot is 0 during LOAD and IDLE.
- START_EDGE=1, inicio held high for 20 cycles -> exactly one sequence and one listo pulse; dropping and raising inicio starts a second.
- inicio pulse while dout=2 -> the sequence is unaffected, with no extra listo. With FILTRO_SEQ_OVERRUN_EN, overrun rises one cycle later and stays set until overrun_clr.
- reset asserted asynchronously while dout=1 -> dout=0, busy=0 and listo=0 immediately with no clock edge, and no listo pulse follows.
- N_TAPS=2, back-to-back level starts -> dout pattern 0,1,(LOAD),(IDLE) repeats, and CNT_W=1.
